reg_pipeline: RTL
=================

REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 3: number of register stages, legal range 1..16.
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port en, input, 1: global advance enable; low means the pipeline holds.
REQ-006 Port clr, input, 1: synchronous flush of all stages.
REQ-007 Port in_valid, input, 1: in_data is presented for capture.
REQ-008 Port in_ready, output, 1: stage 0 accepts data this cycle.
REQ-009 Port in_data, input, WIDTH: input word.
REQ-010 Port out_valid, output, 1: the last stage holds a valid word.
REQ-011 Port out_ready, input, 1: the sink consumes out_data this cycle.
REQ-012 Port out_data, output, WIDTH: the last-stage word.
REQ-013 Port occupancy, output, $clog2(DEPTH+1): number of valid stages.

Function
REQ-014 Each stage i holds a data register d[i] (WIDTH bits) and a valid bit v[i].
REQ-015 Define the internal term advance = en AND (NOT v[DEPTH-1] OR out_ready).
REQ-016 in_ready SHALL equal advance combinationally, with clr excluded from the term.
REQ-017 On a clk edge with advance=1 and clr=0, the stages shift:
- d[0] <= in_data and v[0] <= in_valid;
- for i>0: d[i] <= d[i-1] and v[i] <= v[i-1].
REQ-018 On a clk edge with advance=0 and clr=0, all d[i] and v[i] SHALL hold.
REQ-019 On a clk edge with clr=1, all v[i] and d[i] SHALL become 0, regardless of en, in_valid or out_ready.
REQ-020 When clr=1, the word offered on in_data that cycle is dropped even if in_ready=1; the source must treat it as lost.
REQ-021 out_valid = v[DEPTH-1] and out_data = d[DEPTH-1], both directly from registers.
REQ-022 Latency: a word accepted at edge t appears on out_data after edge t+DEPTH-1, provided advance=1 on every intervening edge (DEPTH cycles total).
REQ-023 Bubbles (in_valid=0 while advancing) SHALL propagate as v=0 stages; data in invalid stages is don't-care but SHALL shift unchanged.
REQ-024 Holding: while out_valid=1 and out_ready=0, out_data SHALL remain stable and no word is lost or duplicated.
REQ-025 A transfer occurs only when out_valid AND out_ready AND en; while en=0, out_ready is ignored.
REQ-026 occupancy SHALL equal the population count of v[], registered and consistent with v[] every cycle; it is 0 after reset and after clr.
REQ-027 When DEPTH=1, behaviour SHALL reduce to a single enabled, clearable register with valid/ready flow control.

Reset
REQ-028 While rst_n=0, all v[i], all d[i], out_valid, out_data and occupancy SHALL be 0, asynchronously.
REQ-029 in_ready SHALL be 0 while rst_n=0.
REQ-030 Reset asserted mid-stream discards all in-flight words; after deassertion the pipeline starts empty on the first rising edge.

Structure
REQ-031 Each stage SHALL instantiate the existing register module: WIDTH+1 bits (valid bit plus data), with en=advance and clr=clr.
REQ-032 No shared package is required; the occupancy width SHALL be a localparam derived from DEPTH.
REQ-033 Target RTL size is 120-250 lines, using a generate loop over the stages.

Verification (WIDTH=8, DEPTH=3)
REQ-034 Reset then stream: send 0x01, 0x02, 0x03 on consecutive cycles with en=1 and out_ready=1 -> out_data reads 0x01, 0x02, 0x03 starting 3 cycles after the first accept; occupancy reaches 3.
REQ-035 Backpressure: fill with 0x10, 0x20, 0x30, then out_ready=0 for 4 cycles -> out_data holds 0x10, in_ready=0, occupancy=3; release -> 0x10, 0x20, 0x30 appear in order, with no loss and no duplicates.
REQ-036 Bubble: send 0xAA, an idle cycle, then 0xBB -> out_valid pattern 1,0,1, with 0xAA and 0xBB separated by one cycle.
REQ-037 Enable stall: set en=0 for 2 cycles mid-stream -> all stages hold, in_ready=0, and out_ready is ignored.
REQ-038 Flush: with occupancy=3, set clr=1 together with in_valid=1 and in_data=0x55 -> the next cycle shows occupancy=0 and out_valid=0, and 0x55 never appears on the output.
REQ-039 Async reset: drop rst_n between edges while full -> outputs read 0 immediately, before the next edge.

Source files
------------

// File: rtl/reg_pipeline_pkg.sv
// Shared constants and helpers for the valid/ready register pipeline.
// The valid-bit population count is sized for the largest legal depth.
package reg_pipeline_pkg;

  localparam int unsigned MAX_DEPTH = 16;
  localparam int unsigned CNT_W     = 5;

  function automatic logic [CNT_W-1:0] count_valid(input logic [MAX_DEPTH-1:0] vec);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, vec[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_pipeline_reg.sv
// Enabled, synchronously clearable register with asynchronous active-low reset.
// One instance per pipeline stage carries {valid, data}.
module reg_pipeline_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Stage storage: clear wins over enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= {W{1'b0}};
    end else if (i_clr) begin
      r_q <= {W{1'b0}};
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_pipeline.sv
// DEPTH-stage valid/ready register pipeline with global enable, flush and
// a registered occupancy count that always matches the stage valid bits.
module reg_pipeline
  import reg_pipeline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH:0]       w_d [DEPTH];
  logic [WIDTH:0]       w_q [DEPTH];
  logic [DEPTH-1:0]     w_v;
  logic [DEPTH-1:0]     w_v_next;
  logic [MAX_DEPTH-1:0] w_v_pad;
  logic                 w_advance;
  logic [OCC_W-1:0]     r_occ;

  assign w_advance = en & (~w_v[DEPTH-1] | out_ready);
  assign in_ready  = rst_n & w_advance;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign w_d[g] = {in_valid, in_data};
      end else begin : g_body
        assign w_d[g] = w_q[g-1];
      end

      reg_pipeline_reg #(.W(WIDTH + 1)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_advance),
        .i_clr (clr),
        .i_d   (w_d[g]),
        .o_q   (w_q[g])
      );

      assign w_v[g] = w_q[g][WIDTH];
    end
  endgenerate

  // Valid bits as they will be after this edge, so the count lands with them.
  always_comb begin
    w_v_next = w_v;
    if (clr) begin
      w_v_next = {DEPTH{1'b0}};
    end else if (w_advance) begin
      w_v_next[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        w_v_next[i] = w_v[i-1];
      end
    end else begin
      w_v_next = w_v;
    end
    w_v_pad = {MAX_DEPTH{1'b0}};
    w_v_pad[DEPTH-1:0] = w_v_next;
  end

  // Registered occupancy tracking the stage valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= {OCC_W{1'b0}};
    end else begin
      r_occ <= OCC_W'(count_valid(w_v_pad));
    end
  end

  assign occupancy = r_occ;
  assign out_valid = w_q[DEPTH-1][WIDTH];
  assign out_data  = w_q[DEPTH-1][WIDTH-1:0];

endmodule
